// File: rtl/amba_pkg.sv
// Shared interconnect definitions: arbiter state encoding and the credit helper.
package amba_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // A programmed weight of zero still buys one transfer.
  function automatic logic [31:0] max1(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Fixed-priority pick of one set bit; LSB_FIRST selects which end wins.
module priority_encoder #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1,
  parameter int IW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // The last match written wins, so the scan runs away from the preferred end.
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req[i]) begin
          idx   = IW'(i);
          valid = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (req[i]) begin
          idx   = IW'(i);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stdreg.sv
// Plain state register with synchronous active-low clear to all zeros.
module stdreg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant held for up to weight[i]
// acknowledged transfers (locked beats do not spend credit), then priority rotates.
module wrr_arbiter
  import amba_pkg::*;
#(
  parameter int PORTS             = 4,
  parameter int WEIGHT_W          = 4,
  parameter bit LSB_HIGH_PRIORITY = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            request,
  input  logic [PORTS-1:0]            acknowledge,
  input  logic [PORTS-1:0]            lock,
  input  logic [PORTS*WEIGHT_W-1:0]   weight,
  output logic [PORTS-1:0]            grant,
  output logic                        grant_valid,
  output logic [$clog2(PORTS)-1:0]    grant_encoded,
  output logic [WEIGHT_W-1:0]         credit
);

  localparam int IW = $clog2(PORTS);

  typedef struct packed {
    arb_state_e          state;
    logic [PORTS-1:0]    grant;
    logic                grant_valid;
    logic [IW-1:0]       grant_encoded;
    logic [WEIGHT_W-1:0] credit;
    logic [PORTS-1:0]    mask;
  } arb_regs_t;

  localparam int RW = $bits(arb_regs_t);

  arb_regs_t         cur, nxt;
  logic [RW-1:0]     q_bits;

  stdreg #(.W(RW)) u_regs (
    .clk   (clk),
    .rst_n (!rst),
    .d     (nxt),
    .q     (q_bits)
  );
  assign cur = arb_regs_t'(q_bits);

  logic [PORTS-1:0]    masked;
  logic [IW-1:0]       m_idx, u_idx, win;
  logic                m_vld, u_vld;
  logic [WEIGHT_W-1:0] w_sel;
  logic [PORTS-1:0]    ones;

  assign masked = request & cur.mask;
  assign ones   = '1;

  priority_encoder #(.WIDTH(PORTS), .LSB_FIRST(LSB_HIGH_PRIORITY), .IW(IW)) u_pe_masked (
    .req   (masked),
    .idx   (m_idx),
    .valid (m_vld)
  );

  priority_encoder #(.WIDTH(PORTS), .LSB_FIRST(LSB_HIGH_PRIORITY), .IW(IW)) u_pe_all (
    .req   (request),
    .idx   (u_idx),
    .valid (u_vld)
  );

  assign win   = m_vld ? m_idx : u_idx;
  assign w_sel = weight[win*WEIGHT_W +: WEIGHT_W];

  logic rel;

  always_comb begin
    nxt = cur;
    rel = 1'b0;
    unique case (cur.state)
      ARB_IDLE: rel = 1'b1;
      ARB_GRANT: begin
        if (acknowledge[cur.grant_encoded]) begin
          if (!lock[cur.grant_encoded]) begin
            if (cur.credit > WEIGHT_W'(1)) nxt.credit = cur.credit - WEIGHT_W'(1);
            else                           rel        = 1'b1;
          end
        end else if (!request[cur.grant_encoded]) begin
          rel = 1'b1;  // requester gave up mid-grant
        end
      end
      default: rel = 1'b1;
    endcase

    // Re-arbitrate in the releasing cycle so the next owner follows without a bubble.
    if (rel) begin
      if (u_vld) begin
        nxt.state         = ARB_GRANT;
        nxt.grant         = PORTS'(1) << win;
        nxt.grant_valid   = 1'b1;
        nxt.grant_encoded = win;
        nxt.credit        = WEIGHT_W'(max1(32'(w_sel)));
        nxt.mask          = LSB_HIGH_PRIORITY ? (ones << (int'(win) + 1))
                                              : (ones >> (PORTS - int'(win)));
      end else begin
        nxt.state         = ARB_IDLE;
        nxt.grant         = '0;
        nxt.grant_valid   = 1'b0;
        nxt.grant_encoded = '0;
        nxt.credit        = '0;
      end
    end
  end

  assign grant         = cur.grant;
  assign grant_valid   = cur.grant_valid;
  assign grant_encoded = cur.grant_encoded;
  assign credit        = cur.credit;

endmodule
